// File: rtl/present_pkg.sv
// present_pkg: shared definitions for the PRESENT cipher core.
//   - SBOX / INV_SBOX nibble substitution tables
//   - p_layer / inv_p_layer bit permutations and the 16-nibble S-box layers
//   - key_step_80 / key_step_128: one forward or inverse key-schedule step
//     for the two legal key widths (selected by KEY_WIDTH in the key schedule)
//   - state_e: core FSM states
package present_pkg;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  localparam logic [4:0] RND_FIRST = 5'd1;
  localparam logic [4:0] RND_LAST  = 5'd31;

  typedef enum logic [2:0] {
    NOKEY  = 3'd0,
    EXPAND = 3'd1,
    IDLE   = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_e;

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] o;
    logic [5:0]  b;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      b = 6'(n * 4);
      o[b +: 4] = SBOX[s[b +: 4]];
    end
    return o;
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] s);
    logic [63:0] o;
    logic [5:0]  b;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      b = 6'(n * 4);
      o[b +: 4] = INV_SBOX[s[b +: 4]];
    end
    return o;
  endfunction

  // Bit i moves to position 16*i mod 63; bit 63 stays in place.
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] o;
    logic [5:0]  src;
    logic [5:0]  dst;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      src = 6'(i);
      dst = (i == 63) ? 6'd63 : 6'((i * 16) % 63);
      o[dst] = s[src];
    end
    return o;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] s);
    logic [63:0] o;
    logic [5:0]  src;
    logic [5:0]  dst;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      dst = 6'(i);
      src = (i == 63) ? 6'd63 : 6'((i * 16) % 63);
      o[dst] = s[src];
    end
    return o;
  endfunction

  // Forward: rotl 61, S-box top nibble, XOR round into [19:15].
  // Inverse undoes those three operations in reverse order.
  function automatic logic [79:0] key_step_80(input logic [79:0] k,
                                              input logic [4:0]  rnd,
                                              input logic        inv);
    logic [79:0] r;
    if (!inv) begin
      r          = {k[18:0], k[79:19]};
      r[79:76]   = SBOX[r[79:76]];
      r[19:15]   = r[19:15] ^ rnd;
    end else begin
      r          = k;
      r[19:15]   = r[19:15] ^ rnd;
      r[79:76]   = INV_SBOX[r[79:76]];
      r          = {r[60:0], r[79:61]};
    end
    return r;
  endfunction

  // Forward: rotl 61, S-box top two nibbles, XOR round into [66:62].
  function automatic logic [127:0] key_step_128(input logic [127:0] k,
                                                input logic [4:0]   rnd,
                                                input logic         inv);
    logic [127:0] r;
    if (!inv) begin
      r            = {k[66:0], k[127:67]};
      r[127:124]   = SBOX[r[127:124]];
      r[123:120]   = SBOX[r[123:120]];
      r[66:62]     = r[66:62] ^ rnd;
    end else begin
      r            = k;
      r[66:62]     = r[66:62] ^ rnd;
      r[127:124]   = INV_SBOX[r[127:124]];
      r[123:120]   = INV_SBOX[r[123:120]];
      r            = {r[60:0], r[127:61]};
    end
    return r;
  endfunction

endpackage

// File: rtl/present_cipher_core_if.sv
// present_cipher_core_if: handshake bundle of the PRESENT core.
//   key_i/key_load_i/key_ready_o          key load handshake
//   data_i/decrypt_i/in_valid_i/in_ready_o input block handshake
//   data_o/out_valid_o/out_ready_i         result handshake
// master = host/testbench side, slave = core side.
interface present_cipher_core_if #(
  parameter int KEY_WIDTH = 80
);
  logic [KEY_WIDTH-1:0] key_i;
  logic                 key_load_i;
  logic                 key_ready_o;
  logic [63:0]          data_i;
  logic                 decrypt_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [63:0]          data_o;
  logic                 out_valid_o;
  logic                 out_ready_i;

  modport master (
    output key_i, key_load_i, data_i, decrypt_i, in_valid_i, out_ready_i,
    input  key_ready_o, in_ready_o, data_o, out_valid_o
  );

  modport slave (
    input  key_i, key_load_i, data_i, decrypt_i, in_valid_i, out_ready_i,
    output key_ready_o, in_ready_o, data_o, out_valid_o
  );
endinterface

// File: rtl/present_key_schedule.sv
// present_key_schedule: key storage and round-key stepping.
//   clk_i, rst_ni   clock, async active-low reset (clears all key registers)
//   key_i           new cipher key
//   load_key_i      store key_i as K1 and into the round-key register
//   load_rk_i       reload round-key register from K1 or K32 (sel_k32_i)
//   step_i, inv_i   advance round-key register one step forward/inverse
//   rnd_i           round counter used by the step
//   store_k32_i     capture the stepped key as K32
//   rk_o            current round key (top 64 bits)
//   rk_next_o       round key after one step (top 64 bits)
module present_key_schedule
  import present_pkg::*;
#(
  parameter int KEY_WIDTH = 80
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic                 load_key_i,
  input  logic                 load_rk_i,
  input  logic                 sel_k32_i,
  input  logic                 step_i,
  input  logic                 inv_i,
  input  logic [4:0]           rnd_i,
  input  logic                 store_k32_i,
  output logic [63:0]          rk_o,
  output logic [63:0]          rk_next_o
);

  logic [KEY_WIDTH-1:0] rk_q;
  logic [KEY_WIDTH-1:0] k1_q;
  logic [KEY_WIDTH-1:0] k32_q;
  logic [KEY_WIDTH-1:0] rk_d;

  if (KEY_WIDTH == 128) begin : g_k128
    always_comb rk_d = key_step_128(rk_q, rnd_i, inv_i);
  end else begin : g_k80
    always_comb rk_d = key_step_80(rk_q, rnd_i, inv_i);
  end

  assign rk_o      = rk_q[KEY_WIDTH-1 -: 64];
  assign rk_next_o = rk_d[KEY_WIDTH-1 -: 64];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rk_q  <= '0;
      k1_q  <= '0;
      k32_q <= '0;
    end else begin
      if (load_key_i) begin
        k1_q <= key_i;
        rk_q <= key_i;
      end else if (load_rk_i) begin
        rk_q <= sel_k32_i ? k32_q : k1_q;
      end else if (step_i) begin
        rk_q <= rk_d;
      end
      if (store_k32_i) begin
        k32_q <= rk_d;
      end
    end
  end

endmodule

// File: rtl/present_cipher_core.sv
// present_cipher_core: PRESENT block cipher, 80/128-bit key, encrypt or
// decrypt selected per block, one round per clock.
//   clk_i   clock
//   rst_ni  async active-low reset; aborts any work and drops the key
//   bus     present_cipher_core_if.slave: key, input block and result
//           valid/ready handshakes
module present_cipher_core
  import present_pkg::*;
#(
  parameter int KEY_WIDTH = 80
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  present_cipher_core_if.slave  bus
);

  if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
    $error("present_cipher_core: KEY_WIDTH must be 80 or 128");
  end

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        dec_q;
  logic        out_valid_q;
  logic        key_rdy_q;
  logic        idle_q;
  logic [63:0] data_q;
  logic [63:0] st_q;

  logic [63:0] rk;
  logic [63:0] rk_next;
  logic [63:0] mixed;
  logic [63:0] round_out;
  logic        key_acc;
  logic        blk_acc;
  logic        last_rnd;
  logic        ks_step;
  logic        ks_inv;
  logic        ks_store;

  assign bus.key_ready_o = key_rdy_q;
  // A key load in the same cycle takes priority over an offered block.
  assign bus.in_ready_o  = idle_q && !bus.key_load_i;
  assign bus.out_valid_o = out_valid_q;
  assign bus.data_o      = data_q;

  assign key_acc  = bus.key_load_i && key_rdy_q;
  assign blk_acc  = bus.in_valid_i && bus.in_ready_o;
  assign last_rnd = dec_q ? (cnt_q == RND_FIRST) : (cnt_q == RND_LAST);
  assign ks_step  = (state_q == EXPAND) || (state_q == RUN);
  assign ks_inv   = (state_q == RUN) && dec_q;
  assign ks_store = (state_q == EXPAND) && (cnt_q == RND_LAST);

  assign mixed     = st_q ^ rk;
  assign round_out = dec_q ? inv_sbox_layer(inv_p_layer(mixed))
                           : p_layer(sbox_layer(mixed));

  present_key_schedule #(
    .KEY_WIDTH (KEY_WIDTH)
  ) u_key_schedule (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .key_i       (bus.key_i),
    .load_key_i  (key_acc),
    .load_rk_i   (blk_acc),
    .sel_k32_i   (bus.decrypt_i),
    .step_i      (ks_step),
    .inv_i       (ks_inv),
    .rnd_i       (cnt_q),
    .store_k32_i (ks_store),
    .rk_o        (rk),
    .rk_next_o   (rk_next)
  );

  // Cipher state register: datapath only, no reset needed.
  always_ff @(posedge clk_i) begin
    if (blk_acc) begin
      st_q <= bus.data_i;
    end else if (state_q == RUN) begin
      st_q <= round_out;
    end
  end

  // Control FSM. The last round is merged with the final whitening XOR
  // (rk_next is K32 when encrypting, K1 when decrypting) so the result
  // appears 31 cycles after acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= NOKEY;
      cnt_q       <= '0;
      dec_q       <= 1'b0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      key_rdy_q   <= 1'b1;
      idle_q      <= 1'b0;
    end else begin
      case (state_q)
        NOKEY, IDLE: begin
          if (key_acc) begin
            state_q   <= EXPAND;
            cnt_q     <= RND_FIRST;
            key_rdy_q <= 1'b0;
            idle_q    <= 1'b0;
          end else if (blk_acc) begin
            state_q   <= RUN;
            dec_q     <= bus.decrypt_i;
            cnt_q     <= bus.decrypt_i ? RND_LAST : RND_FIRST;
            key_rdy_q <= 1'b0;
            idle_q    <= 1'b0;
          end
        end
        EXPAND: begin
          if (cnt_q == RND_LAST) begin
            state_q   <= IDLE;
            key_rdy_q <= 1'b1;
            idle_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        RUN: begin
          if (last_rnd) begin
            data_q      <= round_out ^ rk_next;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= dec_q ? (cnt_q - 5'd1) : (cnt_q + 5'd1);
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
            key_rdy_q   <= 1'b1;
            idle_q      <= 1'b1;
          end
        end
        default: begin
          state_q     <= NOKEY;
          out_valid_q <= 1'b0;
          key_rdy_q   <= 1'b1;
          idle_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_present_cipher_core.sv
module tb_present_cipher_core;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  present_cipher_core_if #(.KEY_WIDTH(80))  b80 ();
  present_cipher_core_if #(.KEY_WIDTH(128)) b128 ();

  present_cipher_core #(.KEY_WIDTH(80)) dut80 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b80.slave)
  );

  present_cipher_core #(.KEY_WIDTH(128)) dut128 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b128.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load80(input logic [79:0] key, input string tag);
    int n;
    b80.key_i      = key;
    b80.key_load_i = 1'b1;
    tick();
    b80.key_load_i = 1'b0;
    n = 0;
    while (!b80.key_ready_o && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd31);
    chk({tag, "_in_ready"}, 64'(b80.in_ready_o), 64'd1);
  endtask

  task automatic run80(input logic [63:0] din, input logic dec,
                       input logic [63:0] exp, input string tag);
    int n;
    b80.data_i     = din;
    b80.decrypt_i  = dec;
    b80.in_valid_i = 1'b1;
    #1;
    chk({tag, "_ready"}, 64'(b80.in_ready_o), 64'd1);
    tick();
    b80.in_valid_i = 1'b0;
    b80.decrypt_i  = ~dec;
    b80.data_i     = ~din;
    n = 0;
    while (!b80.out_valid_o && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd31);
    chk({tag, "_data"}, b80.data_o, exp);
    b80.out_ready_i = 1'b1;
    tick();
    b80.out_ready_i = 1'b0;
    chk({tag, "_valid_drop"}, 64'(b80.out_valid_o), 64'd0);
    chk({tag, "_in_ready_back"}, 64'(b80.in_ready_o), 64'd1);
    chk({tag, "_data_hold"}, b80.data_o, exp);
  endtask

  task automatic load128(input logic [127:0] key, input string tag);
    int n;
    b128.key_i      = key;
    b128.key_load_i = 1'b1;
    tick();
    b128.key_load_i = 1'b0;
    n = 0;
    while (!b128.key_ready_o && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd31);
  endtask

  task automatic run128(input logic [63:0] din, input logic dec,
                        input logic [63:0] exp, input string tag);
    int n;
    b128.data_i     = din;
    b128.decrypt_i  = dec;
    b128.in_valid_i = 1'b1;
    tick();
    b128.in_valid_i = 1'b0;
    n = 0;
    while (!b128.out_valid_o && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd31);
    chk({tag, "_data"}, b128.data_o, exp);
    b128.out_ready_i = 1'b1;
    tick();
    b128.out_ready_i = 1'b0;
    chk({tag, "_valid_drop"}, 64'(b128.out_valid_o), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [63:0] held;

    rst_n = 1'b0;
    b80.key_i = '0;  b80.key_load_i = 1'b0;  b80.data_i = '0;  b80.decrypt_i = 1'b0;
    b80.in_valid_i = 1'b0;  b80.out_ready_i = 1'b0;
    b128.key_i = '0; b128.key_load_i = 1'b0; b128.data_i = '0; b128.decrypt_i = 1'b0;
    b128.in_valid_i = 1'b0; b128.out_ready_i = 1'b0;
    repeat (2) tick();

    // Reset values
    chk("rst_data", b80.data_o, 64'h0);
    chk("rst_valid", 64'(b80.out_valid_o), 64'd0);
    chk("rst_in_ready", 64'(b80.in_ready_o), 64'd0);
    chk("rst_key_ready", 64'(b80.key_ready_o), 64'd1);
    chk("rst128_key_ready", 64'(b128.key_ready_o), 64'd1);
    rst_n = 1'b1;

    // Block offered with no key is refused
    b80.in_valid_i = 1'b1;
    tick();
    chk("nokey_in_ready", 64'(b80.in_ready_o), 64'd0);
    tick();
    b80.in_valid_i = 1'b0;
    chk("nokey_no_result", 64'(b80.out_valid_o), 64'd0);

    // 80-bit known-answer vectors
    load80(80'h0, "k0");
    run80(64'h0, 1'b0, 64'h5579C1387B228445, "enc_k0_p0");
    run80(64'h5579C1387B228445, 1'b1, 64'h0, "dec_k0_p0");
    load80({80{1'b1}}, "kF");
    run80(64'h0, 1'b0, 64'hE72C46C0F5945049, "enc_kF_p0");
    run80({64{1'b1}}, 1'b0, 64'h3333DCD3213210D2, "enc_kF_pF");
    run80(64'h3333DCD3213210D2, 1'b1, {64{1'b1}}, "dec_kF_pF");
    load80(80'h0, "k0b");
    run80({64{1'b1}}, 1'b0, 64'hA112FFC72F68417B, "enc_k0_pF");

    // Backpressure: result must hold for 10 cycles with out_ready low
    b80.data_i = 64'h0; b80.decrypt_i = 1'b0; b80.in_valid_i = 1'b1;
    tick();
    b80.in_valid_i = 1'b0;
    n = 0;
    while (!b80.out_valid_o && n < 100) begin
      tick();
      n++;
    end
    chk("bp_latency", 64'(n), 64'd31);
    held = b80.data_o;
    chk("bp_data", held, 64'h5579C1387B228445);
    for (int i = 0; i < 10; i++) begin
      b80.in_valid_i = 1'b1;
      b80.key_load_i = 1'b1;
      b80.data_i     = {$urandom, $urandom};
      tick();
      chk("bp_data_stable", b80.data_o, 64'h5579C1387B228445);
      chk("bp_in_ready_low", 64'(b80.in_ready_o), 64'd0);
      chk("bp_valid_high", 64'(b80.out_valid_o), 64'd1);
    end
    b80.in_valid_i  = 1'b0;
    b80.key_load_i  = 1'b0;
    b80.out_ready_i = 1'b1;
    tick();
    b80.out_ready_i = 1'b0;
    chk("bp_valid_drop", 64'(b80.out_valid_o), 64'd0);
    chk("bp_idle_in_ready", 64'(b80.in_ready_o), 64'd1);
    chk("bp_idle_key_ready", 64'(b80.key_ready_o), 64'd1);

    // Key load and block together: key wins
    b80.key_i      = {80{1'b1}};
    b80.key_load_i = 1'b1;
    b80.data_i     = 64'h0;
    b80.in_valid_i = 1'b1;
    #1;
    chk("both_in_ready_low", 64'(b80.in_ready_o), 64'd0);
    tick();
    b80.key_load_i = 1'b0;
    b80.in_valid_i = 1'b0;
    n = 0;
    while (!b80.in_ready_o && n < 100) begin
      tick();
      n++;
    end
    chk("both_in_ready_latency", 64'(n), 64'd31);
    chk("both_no_result", 64'(b80.out_valid_o), 64'd0);
    run80(64'h0, 1'b0, 64'hE72C46C0F5945049, "both_new_key");

    // Reset mid-run
    load80(80'h0, "k0c");
    b80.data_i = 64'h0; b80.decrypt_i = 1'b0; b80.in_valid_i = 1'b1;
    tick();
    b80.in_valid_i = 1'b0;
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_data", b80.data_o, 64'h0);
    chk("abort_valid", 64'(b80.out_valid_o), 64'd0);
    chk("abort_in_ready", 64'(b80.in_ready_o), 64'd0);
    chk("abort_key_ready", 64'(b80.key_ready_o), 64'd1);
    tick();
    rst_n = 1'b1;
    b80.in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_refuse_ready", 64'(b80.in_ready_o), 64'd0);
      chk("abort_refuse_valid", 64'(b80.out_valid_o), 64'd0);
    end
    b80.in_valid_i = 1'b0;
    load80(80'h0, "k0d");
    run80(64'h0, 1'b0, 64'h5579C1387B228445, "after_abort");

    // 128-bit key
    load128(128'h0, "k128");
    run128(64'h0, 1'b0, 64'h96DB702A2E6900AF, "enc128");
    run128(64'h96DB702A2E6900AF, 1'b1, 64'h0, "dec128");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
